// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame capture path.
// Holds the standard 640x480 timing numbers, bus widths, the capture FSM
// state encoding, and the CRC-16-CCITT constants and update function.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 19;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS,
        S_V_BP,
        S_H_WAIT,
        S_CAPTURE,
        S_H_LINE,
        S_DONE
    } state_t;

    // Fold one pixel into the CRC, MSB first, no reflection.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc_in,
                                              input logic [DATA_W-1:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
endpackage

// File: rtl/vga_frame_capture_if.sv
// Image RAM write port.
//   wr_en   : one-clk write strobe per captured pixel
//   wr_addr : linear pixel address x + H_ACTIVE*y
//   wr_data : {R,G,B} 4:4:4 pixel
// master = capture block, slave = RAM.
interface vga_frame_capture_if;
    import vga_pkg::*;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_sync_edge.sv
// Samples hsync/vsync/rgb on each pixel strobe and reports sync edges
// between consecutive samples.
//   clk, reset     : system clock, async active-low reset
//   pix_en         : pixel strobe
//   hsync, vsync   : raw syncs (active-low)
//   rgb            : raw pixel
//   smp_vld        : high the clk after a pix_en; a new sample is present
//   rgb_q          : latest sampled pixel
//   hs_rise/hs_fall, vs_rise/vs_fall : edge pulses, qualified by smp_vld
module vga_sync_edge
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [DATA_W-1:0] rgb,
    output logic              smp_vld,
    output logic [DATA_W-1:0] rgb_q,
    output logic              hs_rise,
    output logic              hs_fall,
    output logic              vs_rise,
    output logic              vs_fall
);
    logic hs_q, hs_p, vs_q, vs_p;

    // Sync history resets to the inactive (high) level so the first
    // sample after reset cannot look like a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp_vld <= 1'b0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            hs_p    <= 1'b1;
            vs_q    <= 1'b1;
            vs_p    <= 1'b1;
        end else begin
            smp_vld <= pix_en;
            if (pix_en) begin
                rgb_q <= rgb;
                hs_p  <= hs_q;
                hs_q  <= hsync;
                vs_p  <= vs_q;
                vs_q  <= vsync;
            end
        end
    end

    assign hs_rise = smp_vld &  hs_q & ~hs_p;
    assign hs_fall = smp_vld & ~hs_q &  hs_p;
    assign vs_rise = smp_vld &  vs_q & ~vs_p;
    assign vs_fall = smp_vld & ~vs_q &  vs_p;
endmodule

// File: rtl/vga_frame_capture.sv
// VGA sink: decodes hsync/vsync/rgb back into pixel coordinates and writes
// one complete active frame into the image RAM, address x + H_ACTIVE*y.
//   clk, reset   : 100 MHz clock, async active-low reset
//   pix_en       : pixel strobe (1 in 4 clk)
//   hsync, vsync : active-low syncs; rgb : pixel, valid with pix_en
//   arm          : pulse, capture the next complete frame
//   busy         : arm accepted, capture in progress
//   done         : sticky, full frame written
//   frame_err    : sticky, sync timing violation aborted the capture
//   wr           : RAM write port (master)
//   crc          : CRC-16-CCITT over written pixels
// Build option: define CAPTURE_CRC_EN to include the CRC; otherwise crc = 0.
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_BP     = vga_pkg::H_BP,     // must be >= 2
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [DATA_W-1:0]    rgb,
    input  logic                 arm,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_err,
    output logic [15:0]          crc,
    vga_frame_capture_if.master  wr
);
    localparam int PC_W = $clog2(H_ACTIVE + H_BP);
    localparam int LC_W = $clog2(V_ACTIVE + V_BP);

    logic              smp_vld, hs_rise, hs_fall, vs_rise, vs_fall;
    logic [DATA_W-1:0] rgb_q;

    vga_sync_edge u_edge (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .hsync   (hsync),
        .vsync   (vsync),
        .rgb     (rgb),
        .smp_vld (smp_vld),
        .rgb_q   (rgb_q),
        .hs_rise (hs_rise),
        .hs_fall (hs_fall),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall)
    );

    state_t            state, state_n;
    logic [PC_W-1:0]   pix_cnt, pix_cnt_n;
    logic [LC_W-1:0]   line_cnt, line_cnt_n;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_fire, take_arm, set_err, set_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        pix_cnt_n  = pix_cnt;
        line_cnt_n = line_cnt;
        wr_fire    = 1'b0;
        take_arm   = 1'b0;
        set_err    = 1'b0;
        set_done   = 1'b0;
        unique case (state)
            S_IDLE: if (arm) begin
                take_arm = 1'b1;
                state_n  = S_WAIT_VS;
            end
            S_WAIT_VS: if (vs_rise) begin
                state_n    = S_V_BP;
                line_cnt_n = '0;
            end
            // The hsync rise that ends back porch is also the one that
            // starts the first line's H_WAIT.
            S_V_BP: if (hs_rise) begin
                if (line_cnt == LC_W'(V_BP - 1)) begin
                    state_n    = S_H_WAIT;
                    pix_cnt_n  = PC_W'(1);
                    line_cnt_n = '0;
                end else begin
                    line_cnt_n = line_cnt + 1'b1;
                end
            end
            // The rise sample itself is back-porch pixel 1.
            S_H_WAIT: if (smp_vld) begin
                if (pix_cnt == PC_W'(H_BP - 1)) begin
                    state_n   = S_CAPTURE;
                    pix_cnt_n = '0;
                end else begin
                    pix_cnt_n = pix_cnt + 1'b1;
                end
            end
            S_CAPTURE: if (smp_vld) begin
                wr_fire = 1'b1;
                if (pix_cnt == PC_W'(H_ACTIVE - 1)) begin
                    pix_cnt_n  = '0;
                    line_cnt_n = line_cnt + 1'b1;
                    state_n    = (line_cnt == LC_W'(V_ACTIVE - 1)) ? S_DONE : S_H_LINE;
                end else begin
                    pix_cnt_n = pix_cnt + 1'b1;
                end
            end
            S_H_LINE: if (hs_rise) begin
                state_n   = S_H_WAIT;
                pix_cnt_n = PC_W'(1);
            end
            S_DONE: begin
                set_done = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Timing violations abort and suppress the write of the bad sample.
        if ((vs_fall && (state inside {S_V_BP, S_H_WAIT, S_CAPTURE, S_H_LINE})) ||
            (hs_fall && (state inside {S_H_WAIT, S_CAPTURE}))) begin
            set_err    = 1'b1;
            wr_fire    = 1'b0;
            state_n    = S_IDLE;
            pix_cnt_n  = '0;
            line_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt   <= '0;
            line_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            pix_cnt  <= pix_cnt_n;
            line_cnt <= line_cnt_n;
            if (take_arm) begin
                busy      <= 1'b1;
                done      <= 1'b0;
                frame_err <= 1'b0;
                wr_addr_q <= '0;
            end
            if (wr_fire)  wr_addr_q <= wr_addr_q + 1'b1;
            if (set_done) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (set_err) begin
                busy      <= 1'b0;
                frame_err <= 1'b1;
            end
        end
    end

    assign wr.wr_en   = wr_fire;
    assign wr.wr_addr = wr_addr_q;
    assign wr.wr_data = rgb_q;

`ifdef CAPTURE_CRC_EN
    logic [15:0] crc_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       crc_q <= CRC_INIT;
        else if (take_arm) crc_q <= CRC_INIT;
        else if (wr_fire)  crc_q <= crc16_upd(crc_q, rgb_q);
    end
    assign crc = crc_q;
`else
    assign crc = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced raster (16x8 active) so that
// several whole frames fit in a short run. A generator produces the VGA
// stream and pushes expected writes; a monitor pops them on wr_en.
module tb_vga_frame_capture;
    localparam int HA = 16, HF = 2, HS = 4, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int LIM = 20000;

    typedef struct {
        int          addr;
        logic [11:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, pix_en, hsync, vsync, arm;
    logic [11:0] rgb;
    logic        busy, done, frame_err;
    logic [15:0] crc;

    vga_frame_capture_if wr_if();

    vga_frame_capture #(.H_ACTIVE(HA), .H_BP(HB), .V_ACTIVE(VA), .V_BP(VB)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .arm(arm), .busy(busy), .done(done), .frame_err(frame_err),
        .crc(crc), .wr(wr_if.master)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    exp_t        sb[$];
    int          hc = 0, vc = 0, ph = 0, stall = 0;
    bit          want = 0, cap = 0, trunc = 0, col = 0;
    int          wr_cnt = 0, last_addr = -1;
    logic [15:0] crc_m = 16'hFFFF;
    logic [11:0] mem [HA*VA];

`ifdef CAPTURE_CRC_EN
    localparam logic [15:0] CRC_RST = 16'hFFFF;
`else
    localparam logic [15:0] CRC_RST = 16'h0000;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 11; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    // Raster generator: one pixel every 4 clk unless stalled.
    initial begin : gen
        exp_t e;
        pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0;
        forever begin
            @(negedge clk);
            pix_en = 1'b0;
            if (stall > 0) stall--;
            else if (ph < 3) ph++;
            else begin
                ph     = 0;
                pix_en = 1'b1;
                hsync  = !((hc >= HA + HF && hc < HA + HF + HS) ||
                           (trunc && vc == 2 && hc >= 5 && hc < 9));
                vsync  = !(vc >= VA + VF && vc < VA + VF + VS);
                rgb    = col ? 12'hF00 : 12'(hc + vc);
                if (want && vc == VA + VF + VS && hc == 0) begin
                    cap  = 1;
                    want = 0;
                end
                if (cap && trunc && vc == 2 && hc == 5) cap = 0;
                if (cap && hc < HA && vc < VA) begin
                    e.addr = hc + HA * vc;
                    e.data = rgb;
                    sb.push_back(e);
                    if (vc == VA - 1 && hc == HA - 1) cap = 0;
                end
                hc++;
                if (hc == HT) begin
                    hc = 0;
                    vc = (vc + 1) % VT;
                end
            end
        end
    end

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset && wr_if.wr_en) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", 32'(wr_if.wr_addr), 32'hFFFFFFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(wr_if.wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_if.wr_data), 32'(e.data));
                crc_m = crc_ref(crc_m, e.data);
            end
            if (wr_if.wr_addr < 19'(HA * VA)) mem[wr_if.wr_addr] = wr_if.wr_data;
            wr_cnt++;
            last_addr = int'(wr_if.wr_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_gen(input int v, input int h, input bit need_cap);
        int n = 0;
        while (!(vc == v && hc == h && (!need_cap || cap)) && n < LIM) begin
            tick();
            n++;
        end
        if (n >= LIM) check("timeout_gen", 32'(n), 32'(0));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < LIM) begin
            tick();
            n++;
        end
        if (n >= LIM) check("timeout_busy", 32'(n), 32'(0));
    endtask

    task automatic start_capture();
        wr_cnt    = 0;
        last_addr = -1;
        crc_m     = 16'hFFFF;
        for (int i = 0; i < HA * VA; i++) mem[i] = 12'hABC;
        want = 1;
        arm_pulse();
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $finish;
    end

    initial begin : stim
        reset = 1'b0;
        arm   = 1'b0;
        repeat (5) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_wr_en", 32'(wr_if.wr_en), 0);
        check("rst_wr_addr", 32'(wr_if.wr_addr), 0);
        check("rst_wr_data", 32'(wr_if.wr_data), 0);
        check("rst_crc", 32'(crc), 32'(CRC_RST));
        reset = 1'b1;

        // Arm mid-frame, ignored re-arm during capture, full frame.
        wait_gen(4, 0, 0);
        start_capture();
        check("a_busy", 32'(busy), 1);
        wait_gen(3, 0, 1);
        arm_pulse();
        wait_idle();
        check("a_done", 32'(done), 1);
        check("a_err", 32'(frame_err), 0);
        check("a_count", 32'(wr_cnt), 32'(HA * VA));
        check("a_last", 32'(last_addr), 32'(HA * VA - 1));
        check("a_sb_empty", 32'(sb.size()), 0);
        check("a_px0", 32'(mem[0]), 32'h000);
        check("a_px17", 32'(mem[17]), 32'h002);
        check("a_px127", 32'(mem[127]), 32'h016);

        // Re-arm right after done, frame truncated on line 2 at x=5.
        trunc = 1;
        start_capture();
        check("b_done_clr", 32'(done), 0);
        check("b_busy", 32'(busy), 1);
        wait_idle();
        check("b_err", 32'(frame_err), 1);
        check("b_done", 32'(done), 0);
        check("b_count", 32'(wr_cnt), 37);
        check("b_last", 32'(last_addr), 36);
        wait_gen(VA + 1, 0, 0);
        check("b_count_after", 32'(wr_cnt), 37);
        check("b_sb_empty", 32'(sb.size()), 0);
        trunc = 0;

        // Async reset mid-capture.
        start_capture();
        wait_gen(2, 3, 1);
        reset = 1'b0;
        cap   = 0;
        want  = 0;
        sb.delete();
        #1;
        check("c_busy", 32'(busy), 0);
        check("c_done", 32'(done), 0);
        check("c_err", 32'(frame_err), 0);
        check("c_wr_en", 32'(wr_if.wr_en), 0);
        check("c_wr_addr", 32'(wr_if.wr_addr), 0);
        check("c_wr_data", 32'(wr_if.wr_data), 0);
        check("c_crc", 32'(crc), 32'(CRC_RST));
        repeat (3) tick();
        reset = 1'b1;

        // Clean rearm with a 100-clk pix_en stall mid-line.
        start_capture();
        wait_gen(3, 7, 1);
        stall = 100;
        wait_idle();
        check("d_done", 32'(done), 1);
        check("d_err", 32'(frame_err), 0);
        check("d_count", 32'(wr_cnt), 32'(HA * VA));
        check("d_last", 32'(last_addr), 32'(HA * VA - 1));
        check("d_sb_empty", 32'(sb.size()), 0);
        check("d_px17", 32'(mem[17]), 32'h002);

        // Constant-colour frame for the CRC.
        col = 1;
        start_capture();
        wait_idle();
        col = 0;
        check("e_done", 32'(done), 1);
        check("e_count", 32'(wr_cnt), 32'(HA * VA));
`ifdef CAPTURE_CRC_EN
        check("e_crc", 32'(crc), 32'(crc_m));
        repeat (20) tick();
        check("e_crc_hold", 32'(crc), 32'(crc_m));
`else
        check("e_crc", 32'(crc), 0);
        repeat (20) tick();
        check("e_crc_hold", 32'(crc), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
